// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - opcode, field position and format definitions shared by encoder and decoder
package instr_pkg;

  localparam logic [5:0] OP_LDI   = 6'b000000;
  localparam logic [5:0] OP_UNA0  = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b000010;
  localparam logic [5:0] OP_STORE = 6'b000011;
  localparam logic [5:0] OP_BIN0  = 6'b000100;
  localparam logic [5:0] OP_BIN1  = 6'b000101;
  localparam logic [5:0] OP_UNA1  = 6'b000110;
  localparam logic [5:0] OP_DUAL0 = 6'b000111;
  localparam logic [5:0] OP_DUAL1 = 6'b001000;
  localparam logic [5:0] OP_BIN2  = 6'b001001;
  localparam logic [5:0] OP_BIN3  = 6'b001010;
  localparam logic [5:0] OP_BIN4  = 6'b001011;
  localparam logic [5:0] OP_BIN5  = 6'b001100;
  localparam logic [5:0] OP_BIN6  = 6'b001101;
  localparam logic [5:0] OP_UNA2  = 6'b001110;
  localparam logic [5:0] OP_BIN7  = 6'b001111;

  // Bit positions inside the 32-bit instruction word
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 26;
  // Upper register slot: rdst1 for imm/unary/load, rdst2 for dual-destination
  localparam int RDST2_HI    = 25;
  localparam int RDST2_LO    = 21;
  // Destination slot of the binary layouts
  localparam int RDST1_HI    = 20;
  localparam int RDST1_LO    = 16;
  localparam int RSRC2_HI    = 9;
  localparam int RSRC2_LO    = 5;
  localparam int RSRC1_HI    = 4;
  localparam int RSRC1_LO    = 0;
  localparam int IMM_HI      = 7;
  localparam int IMM_LO      = 0;
  // STORE keeps its data address high so rsrc1 stays in the usual low slot
  localparam int DADDR_ST_HI = 25;
  localparam int DADDR_ST_LO = 18;

  typedef enum logic [2:0] {
    FMT_IMM,
    FMT_UNARY,
    FMT_LOAD,
    FMT_STORE,
    FMT_BIN,
    FMT_BIN2,
    FMT_ILLEGAL
  } instr_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } enc_state_e;

  function automatic instr_fmt_e fmt_of(input logic [5:0] op);
    instr_fmt_e f;
    case (op)
      OP_LDI:                     f = FMT_IMM;
      OP_UNA0, OP_UNA1, OP_UNA2:  f = FMT_UNARY;
      OP_LOAD:                    f = FMT_LOAD;
      OP_STORE:                   f = FMT_STORE;
      OP_BIN0, OP_BIN1, OP_BIN2, OP_BIN3,
      OP_BIN4, OP_BIN5, OP_BIN6, OP_BIN7:
                                  f = FMT_BIN;
      OP_DUAL0, OP_DUAL1:         f = FMT_BIN2;
      default:                    f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field bundle stream from the loader into the encoder
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_opcode;
  logic [4:0] in_rdst1;
  logic [4:0] in_rdst2;
  logic [4:0] in_rsrc1;
  logic [4:0] in_rsrc2;
  logic [7:0] in_imm;
  logic [7:0] in_addr;

  modport master (
    output in_valid, in_opcode, in_rdst1, in_rdst2, in_rsrc1, in_rsrc2, in_imm, in_addr,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rdst1, in_rdst2, in_rsrc1, in_rsrc2, in_imm, in_addr,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational packer: opcode and fields to instruction word
module instr_pack
  import instr_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rdst1,
  input  logic [4:0]  rdst2,
  input  logic [4:0]  rsrc1,
  input  logic [4:0]  rsrc2,
  input  logic [7:0]  imm,
  input  logic [7:0]  addr,
  output logic [31:0] word,
  output logic        illegal
);

  instr_fmt_e fmt;

  // Place only the fields the format uses; every other bit stays zero
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    fmt     = fmt_of(opcode);
    word[OPC_HI:OPC_LO] = opcode;
    case (fmt)
      FMT_IMM: begin
        word[RDST2_HI:RDST2_LO] = rdst1;
        word[IMM_HI:IMM_LO]     = imm;
      end
      FMT_UNARY: begin
        word[RDST2_HI:RDST2_LO] = rdst1;
        word[RSRC1_HI:RSRC1_LO] = rsrc1;
      end
      FMT_LOAD: begin
        word[RDST2_HI:RDST2_LO] = rdst1;
        word[IMM_HI:IMM_LO]     = addr;
      end
      FMT_STORE: begin
        word[DADDR_ST_HI:DADDR_ST_LO] = addr;
        word[RSRC1_HI:RSRC1_LO]       = rsrc1;
      end
      FMT_BIN: begin
        word[RDST1_HI:RDST1_LO] = rdst1;
        word[RSRC2_HI:RSRC2_LO] = rsrc2;
        word[RSRC1_HI:RSRC1_LO] = rsrc1;
      end
      FMT_BIN2: begin
        word[RDST2_HI:RDST2_LO] = rdst2;
        word[RDST1_HI:RDST1_LO] = rdst1;
        word[RSRC2_HI:RSRC2_LO] = rsrc2;
        word[RSRC1_HI:RSRC1_LO] = rsrc1;
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - program-load engine writing packed instructions into instruction memory
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  instr_encoder_if.slave    in_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_base
);

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  enc_state_e        state;
  enc_state_e        state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              in_ready;
  logic              accept;
  logic              base_ok;
  logic              at_last;
  logic [31:0]       pack_word;
  logic              pack_illegal;

  assign in_if.in_ready = in_ready;
  assign base_ok        = ({1'b0, base_addr} < DEPTH_W);
  assign at_last        = (ptr == LAST_ADDR);

  instr_pack u_pack (
    .opcode  (in_if.in_opcode),
    .rdst1   (in_if.in_rdst1),
    .rdst2   (in_if.in_rdst2),
    .rsrc1   (in_if.in_rsrc1),
    .rsrc2   (in_if.in_rsrc2),
    .imm     (in_if.in_imm),
    .addr    (in_if.in_addr),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Session state register; reset drops straight back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and busy decode; finish beats the FULL transition
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && base_ok) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_if.in_valid;
        if (finish) begin
          state_nxt = ST_IDLE;
        end else if (accept && !pack_illegal && at_last) begin
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        busy = 1'b1;
        if (finish) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pointer, count, write port and status flags, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      wr_count    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_base    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= (state != ST_IDLE) && finish;
      if ((state == ST_IDLE) && start) begin
        if (base_ok) begin
          ptr         <= base_addr;
          wr_count    <= '0;
          err_illegal <= 1'b0;
          err_base    <= 1'b0;
        end else begin
          err_base    <= 1'b1;
        end
      end
      if (accept) begin
        if (pack_illegal) begin
          err_illegal <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= pack_word;
          wr_count  <= wr_count + (ADDR_W+1)'(1);
          if (!at_last) begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, a_finish;
  logic [7:0]  a_base;
  logic        a_mem_we, a_busy, a_done, a_err_illegal, a_err_base;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_wr_count;

  logic        b_start, b_finish;
  logic [7:0]  b_base;
  logic        b_mem_we, b_busy, b_done, b_err_illegal, b_err_base;
  logic [7:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [8:0]  b_wr_count;

  instr_encoder_if a_if ();
  instr_encoder_if b_if ();

  instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base), .finish(a_finish),
    .in_if(a_if), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .wr_count(a_wr_count), .busy(a_busy), .done(a_done),
    .err_illegal(a_err_illegal), .err_base(a_err_base)
  );

  instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base), .finish(b_finish),
    .in_if(b_if), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .wr_count(b_wr_count), .busy(b_busy), .done(b_done),
    .err_illegal(b_err_illegal), .err_base(b_err_base)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  d1, d2, s1, s2;
    logic [7:0]  imm, ad;
    logic        exp_we;
    logic [31:0] exp_w;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoding from the format rules: {illegal, word}
  function automatic logic [32:0] model(input logic [5:0] op, input logic [4:0] d1, d2, s1, s2,
                                        input logic [7:0] imm, ad);
    int unsigned o, w;
    o = op;
    if (o >= 16) return {1'b1, 32'h0};
    w = o << 26;
    if (o == 0)                   w = w + (int'(d1) << 21) + int'(imm);
    else if (o inside {1, 6, 14}) w = w + (int'(d1) << 21) + int'(s1);
    else if (o == 2)              w = w + (int'(d1) << 21) + int'(ad);
    else if (o == 3)              w = w + (int'(ad) << 18) + int'(s1);
    else begin
      w = w + (int'(d1) << 16) + (int'(s2) << 5) + int'(s1);
      if (o inside {7, 8}) w = w + (int'(d2) << 21);
    end
    return {1'b0, w};
  endfunction

  task automatic drive_a(input logic v, input logic [5:0] op, input logic [4:0] d1, d2, s1, s2,
                         input logic [7:0] imm, ad);
    a_if.in_valid = v; a_if.in_opcode = op;
    a_if.in_rdst1 = d1; a_if.in_rdst2 = d2; a_if.in_rsrc1 = s1; a_if.in_rsrc2 = s2;
    a_if.in_imm = imm; a_if.in_addr = ad;
  endtask

  task automatic drive_b(input logic v, input logic [5:0] op, input logic [4:0] d1,
                         input logic [7:0] imm);
    b_if.in_valid = v; b_if.in_opcode = op;
    b_if.in_rdst1 = d1; b_if.in_rdst2 = 5'd0; b_if.in_rsrc1 = 5'd0; b_if.in_rsrc2 = 5'd0;
    b_if.in_imm = imm; b_if.in_addr = 8'd0;
  endtask

  task automatic start_a(input logic [7:0] base);
    a_start = 1'b1; a_base = base;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    logic [32:0] m;
    int          exp_addr;
    int          ptr, base, il;
    logic        v, exp_we;
    logic [5:0]  op;
    logic [4:0]  d1, d2, s1, s2;
    logic [7:0]  imm, ad;

    tbl[0] = '{6'h00, 5'd5,  5'h1F, 5'h1F, 5'h1F, 8'hA7, 8'hFF, 1'b1, 32'h00A000A7};
    tbl[1] = '{6'h03, 5'h1F, 5'h1F, 5'd31, 5'h1F, 8'hFF, 8'h3C, 1'b1, 32'h0CF0001F};
    tbl[2] = '{6'h20, 5'd1,  5'd2,  5'd3,  5'd4,  8'h11, 8'h22, 1'b0, 32'h0};
    tbl[3] = '{6'h02, 5'd3,  5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'h55, 1'b1, 32'h08600055};
    tbl[4] = '{6'h0E, 5'd31, 5'h1F, 5'd1,  5'h1F, 8'hFF, 8'hFF, 1'b1, 32'h3BE00001};
    tbl[5] = '{6'h0F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 1'b1, 32'h3C1F03FF};
    tbl[6] = '{6'h3F, 5'd7,  5'd7,  5'd7,  5'd7,  8'h77, 8'h77, 1'b0, 32'h0};
    tbl[7] = '{6'h08, 5'd0,  5'h1F, 5'd0,  5'd0,  8'hFF, 8'hFF, 1'b1, 32'h23E00000};
    tbl[8] = '{6'h04, 5'd9,  5'd0,  5'd3,  5'd7,  8'h00, 8'h00, 1'b1, 32'h100900E3};
    tbl[9] = '{6'h07, 5'd1,  5'd2,  5'd6,  5'd4,  8'h00, 8'h00, 1'b1, 32'h1C410086};

    rst_n = 1'b0;
    a_start = 0; a_finish = 0; a_base = 0;
    b_start = 0; b_finish = 0; b_base = 0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("reset_we",     a_mem_we, 0);
    chk("reset_addr",   a_mem_addr, 0);
    chk("reset_wdata",  a_mem_wdata, 0);
    chk("reset_count",  a_wr_count, 0);
    chk("reset_busy",   a_busy, 0);
    chk("reset_done",   a_done, 0);
    chk("reset_ready",  a_if.in_ready, 0);
    chk("reset_errs",   {a_err_illegal, a_err_base}, 0);

    // Table vectors, one bundle with an idle gap between each
    start_a(8'd0);
    chk("tbl_ready", a_if.in_ready, 1);
    exp_addr = 0;
    for (int i = 0; i < 10; i++) begin
      drive_a(1, tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].s1, tbl[i].s2, tbl[i].imm, tbl[i].ad);
      tick();
      drive_a(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_we", i), a_mem_we, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_addr", i), a_mem_addr, exp_addr);
        chk($sformatf("tbl%0d_word", i), a_mem_wdata, tbl[i].exp_w);
        exp_addr++;
      end
      chk($sformatf("tbl%0d_count", i), a_wr_count, exp_addr);
      tick();
      chk($sformatf("tbl%0d_we_drop", i), a_mem_we, 0);
    end
    chk("tbl_err_illegal", a_err_illegal, 1);
    a_finish = 1; tick(); a_finish = 0;
    chk("tbl_done", a_done, 1);
    tick();

    // Back-to-back binary then dual-destination writes; new start clears err_illegal
    start_a(8'd0);
    chk("b2b_err_clear", a_err_illegal, 0);
    drive_a(1, 6'h04, 5'd9, 5'd0, 5'd3, 5'd7, 8'h00, 8'h00);
    tick();
    drive_a(1, 6'h07, 5'd1, 5'd2, 5'd6, 5'd4, 8'h00, 8'h00);
    chk("b2b0_we", a_mem_we, 1);
    chk("b2b0_addr", a_mem_addr, 0);
    chk("b2b0_word", a_mem_wdata, 32'h100900E3);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b1_we", a_mem_we, 1);
    chk("b2b1_addr", a_mem_addr, 1);
    chk("b2b1_word", a_mem_wdata, 32'h1C410086);
    tick();
    chk("b2b_we_drop", a_mem_we, 0);

    // start while busy is ignored: pointer keeps running
    start_a(8'd100);
    drive_a(1, 6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 8'h01, 8'h00);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_start_addr", a_mem_addr, 2);
    chk("busy_start_count", a_wr_count, 3);

    // finish together with an accept: word still written, done the cycle after
    drive_a(1, 6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 8'h02, 8'h00);
    a_finish = 1;
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    a_finish = 0;
    chk("fin_acc_we", a_mem_we, 1);
    chk("fin_acc_addr", a_mem_addr, 3);
    chk("fin_acc_word", a_mem_wdata, 32'h00400002);
    chk("fin_acc_done", a_done, 1);
    chk("fin_acc_busy", a_busy, 0);
    tick();
    chk("fin_done_pulse", a_done, 0);
    chk("fin_count", a_wr_count, 4);

    // finish in IDLE does nothing
    a_finish = 1; tick(); a_finish = 0;
    chk("idle_fin_done", a_done, 0);
    tick();
    chk("idle_fin_done2", a_done, 0);

    // Randomised session against the reference model
    base = $urandom_range(0, 150);
    start_a(8'(base));
    ptr = base; il = 0;
    for (int i = 0; i < 80; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
      d1 = 5'($urandom); d2 = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      imm = 8'($urandom); ad = 8'($urandom);
      drive_a(v, op, d1, d2, s1, s2, imm, ad);
      m = model(op, d1, d2, s1, s2, imm, ad);
      exp_we = v && !m[32];
      if (v && m[32]) il = 1;
      tick();
      chk($sformatf("rnd%0d_we", i), a_mem_we, exp_we);
      if (exp_we) begin
        chk($sformatf("rnd%0d_addr", i), a_mem_addr, ptr);
        chk($sformatf("rnd%0d_word op=%0h", i, op), a_mem_wdata, m[31:0]);
        ptr++;
      end
    end
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rnd_err_illegal", a_err_illegal, il);
    chk("rnd_count", a_wr_count, ptr - base);
    a_finish = 1; tick(); a_finish = 0;
    chk("rnd_done", a_done, 1);

    // DEPTH=4: fill from base 2, third bundle refused
    b_start = 1; b_base = 8'd2; tick(); b_start = 0;
    drive_b(1, 6'h00, 5'd1, 8'h01);
    tick();
    chk("full0_we", b_mem_we, 1);
    chk("full0_addr", b_mem_addr, 2);
    chk("full0_word", b_mem_wdata, 32'h00200001);
    drive_b(1, 6'h00, 5'd2, 8'h02);
    tick();
    chk("full1_we", b_mem_we, 1);
    chk("full1_addr", b_mem_addr, 3);
    chk("full1_word", b_mem_wdata, 32'h00400002);
    chk("full_ready", b_if.in_ready, 0);
    chk("full_busy", b_busy, 1);
    drive_b(1, 6'h00, 5'd3, 8'h03);
    tick();
    chk("full2_we", b_mem_we, 0);
    chk("full2_ready", b_if.in_ready, 0);
    chk("full_count", b_wr_count, 2);
    drive_b(0, 0, 0, 0);
    b_finish = 1; tick(); b_finish = 0;
    chk("full_done", b_done, 1);
    chk("full_busy_end", b_busy, 0);
    chk("full_count_end", b_wr_count, 2);
    tick();
    chk("full_done_pulse", b_done, 0);

    // Out-of-range base, then a valid start clears the flag
    b_start = 1; b_base = 8'd5; tick(); b_start = 0;
    chk("base_err", b_err_base, 1);
    chk("base_err_busy", b_busy, 0);
    chk("base_err_ready", b_if.in_ready, 0);
    b_start = 1; b_base = 8'd1; tick(); b_start = 0;
    chk("base_err_clear", b_err_base, 0);
    chk("base_ok_busy", b_busy, 1);

    // Reset asserted the cycle after an accept clears everything at once
    drive_b(1, 6'h00, 5'd4, 8'h44);
    tick();
    drive_b(0, 0, 0, 0);
    chk("rst_pre_we", b_mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", b_mem_we, 0);
    chk("rst_addr", b_mem_addr, 0);
    chk("rst_wdata", b_mem_wdata, 0);
    chk("rst_count", b_wr_count, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_ready", b_if.in_ready, 0);
    tick();
    chk("rst_hold_we", b_mem_we, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_idle_busy", b_busy, 0);
    chk("rst_idle_ready", b_if.in_ready, 0);
    chk("rst_idle_we", b_mem_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Program-load engine for the 8-bit Harvard core; the inverse of the instruction field decoder.
- Accepts instruction fields (opcode, registers, immediate, data address) over a valid/ready stream and packs them into the 32-bit instruction format.
- Writes each packed word sequentially into instruction memory from a programmable base address.
- Sits between the boot/host loader and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of instruction words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a load session at base_addr.
- base_addr  in  ADDR_W  first instruction memory address of the session.
- finish  in  1  pulse: end the session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_opcode  in  6  opcode.
- in_rdst1, in_rdst2, in_rsrc1, in_rsrc2  in  5 each  register fields.
- in_imm  in  8  immediate value.
- in_addr  in  8  data memory address (source for LOAD, destination for STORE).
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction word.
- wr_count  out  ADDR_W+1  words written this session.
- busy  out  1  state is LOAD or FULL.
- done  out  1  one-cycle pulse when the session ends.
- err_illegal  out  1  sticky: an illegal opcode was presented.
- err_base  out  1  sticky: start was given with base_addr >= DEPTH.

Behaviour:
- Reset (asynchronous, immediate, including mid-session): state IDLE; all outputs 0; address pointer and count 0. No write may issue on or after reset assertion.
- Encoding: all unlisted bits are 0 and [31:26] = opcode.
  - 000000 LDI: [25:21] = rdst1, [7:0] = imm.
  - 000001, 000110, 001110 (unary): [25:21] = rdst1, [4:0] = rsrc1.
  - 000010 LOAD: [25:21] = rdst1, [7:0] = addr.
  - 000011 STORE: [25:18] = addr, [4:0] = rsrc1.
  - 000100, 000101, 001001-001101, 001111 (binary): [20:16] = rdst1, [9:5] = rsrc2, [4:0] = rsrc1.
  - 000111, 001000 (dual-destination): binary layout plus [25:21] = rdst2.
  - 010000-111111: illegal.
- FSM states IDLE, LOAD, FULL.
- IDLE: in_ready = 0.
  - start with base_addr < DEPTH -> LOAD; ptr = base_addr; wr_count = 0; err_illegal cleared.
  - start with base_addr >= DEPTH -> stay IDLE; err_base = 1.
  - err_base is cleared by the next valid start.
- LOAD: in_ready = 1; a handshake occurs when in_valid && in_ready.
  - Legal accept: next cycle mem_we = 1, mem_addr = ptr, mem_wdata = encoded word (latency 1, registered outputs). ptr and wr_count then increment.
  - Illegal accept: the bundle is consumed, nothing is written, ptr is unchanged, err_illegal = 1.
  - A legal write to address DEPTH-1 -> FULL; ptr does not wrap.
  - finish -> IDLE with done pulsed the following cycle. A bundle accepted in the same cycle as finish is still written.
- FULL: in_ready = 0; in_valid is ignored; finish -> IDLE with done pulse.
- start while busy is ignored.
- finish while IDLE is ignored; done stays 0.
- mem_we is high for exactly one cycle per legal accept; back-to-back accepts give back-to-back writes.

Decomposition:
- Shared package instr_pkg:
  - opcode constants (OP_LDI, OP_LOAD, OP_STORE, ...).
  - field bit-position constants (RDST2_HI/LO, RDST1, RSRC2, RSRC1, IMM, DADDR).
  - instruction format enum: FMT_IMM, FMT_UNARY, FMT_LOAD, FMT_STORE, FMT_BIN, FMT_BIN2, FMT_ILLEGAL.
  - The field decoder uses this same package.
- One combinational sub-module, instr_pack: opcode plus fields in -> 32-bit word and illegal flag out.
- The top level holds the FSM, pointer, count, and output registers.

Test Plan:
- start, base 0; LDI rdst1=5 imm=0xA7 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00A000A7; wr_count=1.
- Opcode 000100 with rsrc1=3, rsrc2=7, rdst1=9, followed back-to-back by opcode 000111 with rdst2=2, rdst1=1, rsrc2=4, rsrc1=6 -> writes 0x100900E3 @0, then 0x1C410086 @1 on consecutive cycles.
- STORE addr=0x3C rsrc1=31 -> 0x0CF0001F. Then opcode 0x20 -> no mem_we, err_illegal=1, next legal word lands at address 1.
- DEPTH=4, base 2, three valid bundles -> writes @2 and @3, FULL, in_ready=0, third bundle not accepted. Then finish -> done pulse, wr_count=2, busy=0.
- start with base 5 at DEPTH=4 -> err_base=1, state stays IDLE, in_ready=0.
- rst_n low in the cycle after an accept -> mem_we=0 immediately, all outputs 0. After release, in IDLE.
